// File: rtl/uart_rx_pkg.sv
// Shared frame constants and FSM state encoding for the 8N1 UART receiver.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam logic       RX_IDLE_LEVEL = 1'b1;
  localparam logic [3:0] MID_TICK      = 4'd7;
  localparam logic [3:0] LAST_TICK     = 4'd15;
  localparam int         DATA_BITS     = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO: data_out always shows the oldest entry.
module uart_rx_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write,
  input  logic       read,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       present,
  output logic       half_full,
  output logic       full
);
  localparam int             DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_HALF = (FIFO_AW+1)'(DEPTH / 2);

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_rd, do_wr;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign do_rd = read && (count != '0);
  assign do_wr = write && ((count != CNT_FULL) || do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign data_out  = mem[rd_ptr];
  assign present   = (count != '0);
  assign half_full = (count >= CNT_HALF);
  assign full      = (count == CNT_FULL);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled on en_16_x_baud, feeding a FWFT byte FIFO.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_16_x_baud,
  input  logic       serial_in,
  input  logic       read_buffer,
  output logic [7:0] data_out,
  output logic       buffer_data_present,
  output logic       buffer_half_full,
  output logic       buffer_full,
  output logic       framing_error,
  output logic       overrun
);
  rx_state_e              state;
  logic [1:0]             rx_pipe;
  logic                   rx_sync;
  logic [3:0]             tick_cnt;
  logic [2:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   resolve, fifo_wr;

  always_ff @(posedge clk) begin
    if (reset) rx_pipe <= {2{RX_IDLE_LEVEL}};
    else       rx_pipe <= {rx_pipe[0], serial_in};
  end
  assign rx_sync = rx_pipe[1];

  assign resolve = en_16_x_baud && (state == STOP) && (tick_cnt == LAST_TICK);
  assign fifo_wr = resolve && rx_sync && (!buffer_full || read_buffer);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      if (en_16_x_baud) begin
        unique case (state)
          IDLE: if (rx_sync != RX_IDLE_LEVEL) begin
            state    <= START;
            tick_cnt <= '0;
          end
          START: if (tick_cnt == MID_TICK) begin
            // Still low at mid start bit: a real frame, otherwise a glitch.
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_sync ? IDLE : DATA;
          end else tick_cnt <= tick_cnt + 1'b1;
          DATA: if (tick_cnt == LAST_TICK) begin
            tick_cnt  <= '0;
            shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'(DATA_BITS - 1)) state <= STOP;
          end else tick_cnt <= tick_cnt + 1'b1;
          STOP: if (tick_cnt == LAST_TICK) begin
            tick_cnt <= '0;
            state    <= IDLE;
            if (!rx_sync)                        framing_error <= 1'b1;
            else if (buffer_full && !read_buffer) overrun      <= 1'b1;
          end else tick_cnt <= tick_cnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

  uart_rx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .write     (fifo_wr),
    .read      (read_buffer),
    .data_in   (shift_reg),
    .data_out  (data_out),
    .present   (buffer_data_present),
    .half_full (buffer_half_full),
    .full      (buffer_full)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx against a queue-based model of the receive FIFO and flags.
module tb_uart_rx;
  localparam int DIV     = 4;
  localparam int BIT_CYC = 16 * DIV;
  localparam int DEPTH   = 16;

  logic       clk = 1'b0;
  logic       reset, en_16_x_baud, serial_in, read_buffer;
  logic [7:0] data_out;
  logic       buffer_data_present, buffer_half_full, buffer_full;
  logic       framing_error, overrun;

  int         div = 0;
  int         n_chk = 0, n_pass = 0;
  int         fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
  logic [7:0] q[$];

  uart_rx #(.FIFO_AW(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .en_16_x_baud        (en_16_x_baud),
    .serial_in           (serial_in),
    .read_buffer         (read_buffer),
    .data_out            (data_out),
    .buffer_data_present (buffer_data_present),
    .buffer_half_full    (buffer_half_full),
    .buffer_full         (buffer_full),
    .framing_error       (framing_error),
    .overrun             (overrun)
  );

  always #5 clk = ~clk;

  // Flags count high cycles, so one event must give exactly one.
  always @(negedge clk) begin
    if (framing_error) fe_cnt <= fe_cnt + 1;
    if (overrun)       ov_cnt <= ov_cnt + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs and the baud enable change only at falling edges.
  task automatic cycle();
    @(negedge clk);
    div = (div + 1) % DIV;
    en_16_x_baud = (div == 0);
  endtask

  task automatic align();
    do cycle(); while (!en_16_x_baud);
    cycle();
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".present"}, buffer_data_present, q.size() > 0);
    chk({tag, ".half"},    buffer_half_full,    q.size() >= DEPTH/2);
    chk({tag, ".full"},    buffer_full,         q.size() == DEPTH);
    if (q.size() > 0) chk({tag, ".data"}, data_out, q[0]);
    chk({tag, ".fe"}, fe_cnt, exp_fe);
    chk({tag, ".ov"}, ov_cnt, exp_ov);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".data"},    data_out,            0);
    chk({tag, ".present"}, buffer_data_present, 0);
    chk({tag, ".half"},    buffer_half_full,    0);
    chk({tag, ".full"},    buffer_full,         0);
    chk({tag, ".fe_pin"},  framing_error,       0);
    chk({tag, ".ov_pin"},  overrun,             0);
  endtask

  task automatic rd();
    chk("rd.data", data_out, q[0]);
    read_buffer = 1'b1;
    cycle();
    read_buffer = 1'b0;
    void'(q.pop_front());
    cycle();
  endtask

  // Receiver resolves the stop bit 9 ticks into it: the 36th rising edge after it starts.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit chain, input bit rd_rsv);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    if (!chain) align();
    for (int i = 0; i < 10; i++) begin
      serial_in = bits[i];
      if (i == 9 && rd_rsv) begin
        repeat (35) cycle();
        chk("rsv.full", buffer_full, 1);
        chk("rsv.data", data_out, q[0]);
        read_buffer = 1'b1;
        cycle();
        read_buffer = 1'b0;
        void'(q.pop_front());
        repeat (BIT_CYC - 36) cycle();
      end else repeat (BIT_CYC) cycle();
    end
    if (!stop) exp_fe++;
    else if (q.size() < DEPTH) q.push_back(b);
    else exp_ov++;
    if (!stop) begin
      serial_in = 1'b1;
      repeat (30 * DIV) cycle();
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [9:0] part;
    serial_in = 1'b1; read_buffer = 1'b0; en_16_x_baud = 1'b0; reset = 1'b1;
    repeat (4) cycle();
    reset = 1'b0;
    cycle();
    chk_reset("rst");

    // single byte, then pop it
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    chk_status("t1");
    chk("t1.byte", data_out, 8'hA5);
    rd();
    chk_status("t1.pop");

    // one-tick low glitch is rejected, receiver still takes the next frame
    align();
    serial_in = 1'b0;
    repeat (DIV) cycle();
    serial_in = 1'b1;
    repeat (40 * DIV) cycle();
    chk_status("t2");
    send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
    chk_status("t2.after");

    // bad stop bit with one byte already buffered
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk_status("t3");
    rd();
    read_buffer = 1'b1;
    cycle();
    read_buffer = 1'b0;
    cycle();
    chk_status("t3.rd_empty");

    // fill past capacity back to back, then drain in order
    for (int k = 0; k < 17; k++) begin
      send_frame(8'(k), 1'b1, k > 0, 1'b0);
      chk_status($sformatf("t4.wr%0d", k));
    end
    for (int k = 0; k < 16; k++) rd();
    chk_status("t4.drained");

    // reset in the middle of data bit 4, then a clean 0x81
    part = {1'b1, 8'h5A, 1'b0};
    align();
    for (int i = 0; i < 5; i++) begin
      serial_in = part[i];
      repeat (BIT_CYC) cycle();
    end
    serial_in = part[5];
    repeat (BIT_CYC / 2) cycle();
    reset = 1'b1;
    serial_in = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    q.delete();
    cycle();
    chk_reset("t5.rst");
    repeat (20 * DIV) cycle();
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    chk_status("t5");
    rd();
    chk_status("t5.pop");

    // full FIFO with a pop on the resolve cycle: write accepted, no overrun
    for (int k = 0; k < 16; k++) send_frame(8'($urandom), 1'b1, k > 0, 1'b0);
    chk_status("t6.full");
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b1, 1'b1);
    chk_status("t6.rsv");
    while (q.size() > 0) rd();
    chk_status("t6.drained");

    // random traffic: random bytes, occasional bad stop, random reads and gaps
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 20)) cycle();
      send_frame(8'($urandom), ($urandom_range(0, 5) != 0), 1'b0, 1'b0);
      if (q.size() > 0 && $urandom_range(0, 2) == 0) rd();
      chk_status($sformatf("rnd%0d", k));
    end
    while (q.size() > 0) rd();
    chk_status("end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
